// File: rtl/bht_update_sched.sv
// Buffers ROB branch resolutions and issues one BHT update pulse per cycle, strictly in FIFO order.
// Latency is 2 cycles from accept to pulse; with BHT_UPD_BYPASS_EN an empty, unheld FIFO gives 1 cycle.
// Backpressure: upd_ready drops when the FIFO is full or rdy is low; drain_hold and rdy stall draining.
module bht_update_sched #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [IDX_W-1:0]             upd_idx,
    input  logic                         upd_miss,
    input  logic                         drain_hold,
    output logic                         bht_needchange,
    output logic                         bht_needchange2,
    output logic [IDX_W-1:0]             bht_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Each entry holds {index, miss}.
    logic [IDX_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               push_ok;
    logic               pop;
    logic               bypass;
    logic               wr;

    assign upd_ready = rdy && !rst && (count < CNT_W'(DEPTH));
    assign idle      = (count == '0) && !bht_needchange && !bht_needchange2;

    always_comb begin
        push_ok = upd_valid && upd_ready;
        pop     = rdy && !drain_hold && (count != '0);
`ifdef BHT_UPD_BYPASS_EN
        bypass  = rdy && !drain_hold && (count == '0) && push_ok;
`else
        bypass  = 1'b0;
`endif
        wr      = push_ok && !bypass;
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= {upd_idx, upd_miss};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            bht_needchange  <= 1'b0;
            bht_needchange2 <= 1'b0;
            bht_id          <= '0;
        end else if (rdy) begin
            if (wr) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head            <= head + 1'b1;
                bht_id          <= mem[head][IDX_W:1];
                bht_needchange  <= mem[head][0];
                bht_needchange2 <= !mem[head][0];
            end else if (bypass) begin
                bht_id          <= upd_idx;
                bht_needchange  <= upd_miss;
                bht_needchange2 <= !upd_miss;
            end else begin
                bht_needchange  <= 1'b0;
                bht_needchange2 <= 1'b0;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end else begin
            // Frozen, but a pulse never outlives the cycle it was issued for.
            bht_needchange  <= 1'b0;
            bht_needchange2 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bht_update_sched.sv
// Randomized plus directed bench for bht_update_sched, checked against a queue-based reference model.
module tb_bht_update_sched;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_miss;
    logic             drain_hold;
    logic             bht_needchange;
    logic             bht_needchange2;
    logic [IDX_W-1:0] bht_id;
    logic [2:0]       count;
    logic             idle;

    bht_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_miss(upd_miss),
        .drain_hold(drain_hold),
        .bht_needchange(bht_needchange), .bht_needchange2(bht_needchange2),
        .bht_id(bht_id), .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: pending updates and what the output registers should show.
    logic [IDX_W:0]   q[$];
    logic             m_nc;
    logic             m_nc2;
    logic [IDX_W-1:0] m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic v,
                        input logic [IDX_W-1:0] ix, input logic ms, input logic h);
        logic           acc;
        logic           byp;
        logic [IDX_W:0] e;
        @(negedge clk);
        check("needchange",  32'(bht_needchange),  32'(m_nc));
        check("needchange2", 32'(bht_needchange2), 32'(m_nc2));
        check("bht_id",      32'(bht_id),          32'(m_id));
        check("count",       32'(count),           32'(q.size()));
        check("idle",        32'(idle),            32'(q.size() == 0 && !m_nc && !m_nc2));
        rst = r; rdy = rd; upd_valid = v; upd_idx = ix; upd_miss = ms; drain_hold = h;
        #1;
        check("upd_ready", 32'(upd_ready), 32'(rd && !r && q.size() < DEPTH));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_nc = 1'b0; m_nc2 = 1'b0; m_id = '0;
        end else if (!rd) begin
            m_nc = 1'b0; m_nc2 = 1'b0;
        end else begin
            acc = v && (q.size() < DEPTH);
            byp = 1'b0;
`ifdef BHT_UPD_BYPASS_EN
            byp = acc && !h && (q.size() == 0);
`endif
            if (!h && q.size() > 0) begin
                e = q.pop_front();
                m_id = e[IDX_W:1]; m_nc = e[0]; m_nc2 = !e[0];
            end else if (byp) begin
                m_id = ix; m_nc = ms; m_nc2 = !ms;
            end else begin
                m_nc = 1'b0; m_nc2 = 1'b0;
            end
            if (acc && !byp) q.push_back({ix, ms});
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_miss = 1'b0; drain_hold = 1'b0;
        m_nc = 1'b0; m_nc2 = 1'b0; m_id = '0;
        @(posedge clk);
        @(posedge clk);

        // Reset state, including upd_ready low while rst is asserted.
        step(1, 1, 0, '0, 0, 0);
        idle_cycles(1);

        // Single mispredicted update.
        step(0, 1, 1, 8'h15, 1, 0);
        idle_cycles(3);

        // Fill to full under hold, overflow refused, then ordered drain.
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 1, IDX_W'(i), 1'(i & 1), 1);
        step(0, 1, 1, 8'h55, 1, 1);
        idle_cycles(DEPTH + 2);

        // Steady push/pop at count 2.
        step(0, 1, 1, 8'h07, 0, 1);
        step(0, 1, 1, 8'h07, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 8'h07, 1'(i & 1), 0);
        idle_cycles(4);

        // rdy low freezes a partially full FIFO.
        for (int i = 0; i < 3; i++) step(0, 1, 1, IDX_W'(8'h30 + i), 1'(i & 1), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hEE, 1, 0);
        idle_cycles(5);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) step(0, 1, 1, IDX_W'(8'h40 + i), 1, 1);
        step(0, 1, 0, '0, 0, 0);
        step(1, 1, 0, '0, 0, 0);
        idle_cycles(3);

        // Empty FIFO push, unheld then held.
        step(0, 1, 1, 8'h2A, 0, 0);
        idle_cycles(2);
        step(0, 1, 1, 8'h2A, 0, 1);
        step(0, 1, 0, '0, 0, 1);
        idle_cycles(3);

        // Random traffic in phases with different hold/rdy pressure.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < 85,
                     $urandom_range(0, 99) < 40 + 10 * ph,
                     IDX_W'($urandom),
                     1'($urandom),
                     $urandom_range(0, 99) < 10 * (ph % 4) + 5);
            end
        end
        idle_cycles(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
